// File: rtl/axis_cpu_pkt_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_cpu_pkt_arb
// Purpose  : Packet-level arbiter sharing one axis_cpu datapath between two
//            AXI-Stream requesters. Whole TLAST-delimited input packets are
//            granted to the CPU din port; the winner is recorded in a tag
//            FIFO, and each CPU dout packet is steered back to the requester
//            at the FIFO head.
// Build    : define AXIS_CPU_ARB_RR_EN for round-robin arbitration; otherwise
//            requester 0 has fixed priority.
// Ports    : clk                 sole clock, rising edge
//            rst                 asynchronous reset, active low
//            s0_*/s1_*           requester input streams (slave side)
//            cpu_din_*           stream towards axis_cpu din (master side)
//            cpu_dout_*          stream from axis_cpu dout (slave side)
//            m0_*/m1_*           result streams back to requesters
//            busy                grant locked (ingress BUSY state)
//            tag_count           packets granted, result not yet returned
// Revision : 1.0  initial release
// ============================================================================
module axis_cpu_pkt_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_DEPTH_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [DATA_WIDTH-1:0]     s0_TDATA,
  input  logic                      s0_TVALID,
  output logic                      s0_TREADY,
  input  logic                      s0_TLAST,

  input  logic [DATA_WIDTH-1:0]     s1_TDATA,
  input  logic                      s1_TVALID,
  output logic                      s1_TREADY,
  input  logic                      s1_TLAST,

  output logic [DATA_WIDTH-1:0]     cpu_din_TDATA,
  output logic                      cpu_din_TVALID,
  input  logic                      cpu_din_TREADY,
  output logic                      cpu_din_TLAST,

  input  logic [DATA_WIDTH-1:0]     cpu_dout_TDATA,
  input  logic                      cpu_dout_TVALID,
  output logic                      cpu_dout_TREADY,
  input  logic                      cpu_dout_TLAST,

  output logic [DATA_WIDTH-1:0]     m0_TDATA,
  output logic                      m0_TVALID,
  input  logic                      m0_TREADY,
  output logic                      m0_TLAST,

  output logic [DATA_WIDTH-1:0]     m1_TDATA,
  output logic                      m1_TVALID,
  input  logic                      m1_TREADY,
  output logic                      m1_TLAST,

  output logic                      busy,
  output logic [TAG_DEPTH_LOG2:0]   tag_count
);

  localparam int                    DEPTH     = 1 << TAG_DEPTH_LOG2;
  localparam logic [TAG_DEPTH_LOG2:0] DEPTH_CNT = (TAG_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic [TAG_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH_LOG2:0]   count_q, count_d;
  // One-bit tags packed into a vector, indexed by the pointers.
  logic [DEPTH-1:0]          tag_mem_q, tag_mem_d;
`ifdef AXIS_CPU_ARB_RR_EN
  logic                      last_grant_q, last_grant_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic w_busy;
  logic w_any_req;
  logic w_both_req;
  logic w_sel;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_in_valid;
  logic w_in_last;
  logic w_in_flit_last;
  logic w_dout_ready;
  logic w_m0_sel;
  logic w_m1_sel;

  always_comb begin
    w_busy       = (state_q == ST_BUSY);
    w_any_req    = s0_TVALID | s1_TVALID;
    w_both_req   = s0_TVALID & s1_TVALID;
    w_fifo_full  = (count_q == DEPTH_CNT);
    w_fifo_empty = (count_q == '0);
    w_head       = tag_mem_q[rd_ptr_q];

`ifdef AXIS_CPU_ARB_RR_EN
    // Contention alternates; a lone requester always wins.
    w_sel = w_both_req ? ~last_grant_q : s1_TVALID;
`else
    // Requester 0 wins whenever it is valid.
    w_sel = ~s0_TVALID;
`endif

    // Fullness uses the registered count only: a slot freed by a pop in the
    // same cycle cannot be reused until the next cycle.
    w_push = (state_q == ST_IDLE) & w_any_req & ~w_fifo_full;

    // Selected ingress stream while a grant is locked.
    w_in_valid     = w_busy & (grant_q ? s1_TVALID : s0_TVALID);
    w_in_last      = w_busy & (grant_q ? s1_TLAST  : s0_TLAST);
    w_in_flit_last = w_in_valid & cpu_din_TREADY & w_in_last;

    // Egress steering from the FIFO head; nothing moves with an empty FIFO.
    w_m0_sel     = ~w_fifo_empty & ~w_head;
    w_m1_sel     = ~w_fifo_empty &  w_head;
    w_dout_ready = (w_m0_sel & m0_TREADY) | (w_m1_sel & m1_TREADY);
    w_pop        = cpu_dout_TVALID & w_dout_ready & cpu_dout_TLAST;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_mem_d = tag_mem_q;
`ifdef AXIS_CPU_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (w_push) begin
          state_d = ST_BUSY;
          grant_d = w_sel;
`ifdef AXIS_CPU_ARB_RR_EN
          last_grant_d = w_sel;
`endif
        end
      end
      ST_BUSY: begin
        if (w_in_flit_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_push) begin
      tag_mem_d[wr_ptr_q] = w_sel;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leaves the count unchanged.
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_mem_q <= '0;
`ifdef AXIS_CPU_ARB_RR_EN
      // Starting at 1 makes requester 0 win the first contention.
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_mem_q <= tag_mem_d;
`ifdef AXIS_CPU_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (data gated to zero when the path is not selected)
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = w_busy;
    tag_count = count_q;

    s0_TREADY = w_busy & ~grant_q & cpu_din_TREADY;
    s1_TREADY = w_busy &  grant_q & cpu_din_TREADY;

    cpu_din_TVALID = w_in_valid;
    cpu_din_TLAST  = w_in_last;
    cpu_din_TDATA  = '0;
    if (w_busy) begin
      cpu_din_TDATA = grant_q ? s1_TDATA : s0_TDATA;
    end

    cpu_dout_TREADY = w_dout_ready;

    m0_TVALID = w_m0_sel & cpu_dout_TVALID;
    m0_TLAST  = w_m0_sel & cpu_dout_TLAST;
    m0_TDATA  = w_m0_sel ? cpu_dout_TDATA : '0;

    m1_TVALID = w_m1_sel & cpu_dout_TVALID;
    m1_TLAST  = w_m1_sel & cpu_dout_TLAST;
    m1_TDATA  = w_m1_sel ? cpu_dout_TDATA : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_cpu_pkt_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_cpu_pkt_arb
// Purpose  : Self-checking bench for axis_cpu_pkt_arb. Requesters and an echo
//            CPU are modelled with queues; a transaction-level reference
//            model predicts grants, handshakes, tag occupancy and steering.
// Revision : 1.0  initial release
// ============================================================================
module tb_axis_cpu_pkt_arb;

  localparam int DW    = 32;
  localparam int TL2   = 2;
  localparam int DEPTH = 1 << TL2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s0_TDATA, s1_TDATA, cpu_din_TDATA, cpu_dout_TDATA, m0_TDATA, m1_TDATA;
  logic          s0_TVALID, s0_TREADY, s0_TLAST;
  logic          s1_TVALID, s1_TREADY, s1_TLAST;
  logic          cpu_din_TVALID, cpu_din_TREADY, cpu_din_TLAST;
  logic          cpu_dout_TVALID, cpu_dout_TREADY, cpu_dout_TLAST;
  logic          m0_TVALID, m0_TREADY, m0_TLAST;
  logic          m1_TVALID, m1_TREADY, m1_TLAST;
  logic          busy;
  logic [TL2:0]  tag_count;

  always #5 clk = ~clk;

  axis_cpu_pkt_arb #(.DATA_WIDTH(DW), .TAG_DEPTH_LOG2(TL2)) dut (
    .clk(clk), .rst(rst),
    .s0_TDATA(s0_TDATA), .s0_TVALID(s0_TVALID), .s0_TREADY(s0_TREADY), .s0_TLAST(s0_TLAST),
    .s1_TDATA(s1_TDATA), .s1_TVALID(s1_TVALID), .s1_TREADY(s1_TREADY), .s1_TLAST(s1_TLAST),
    .cpu_din_TDATA(cpu_din_TDATA), .cpu_din_TVALID(cpu_din_TVALID),
    .cpu_din_TREADY(cpu_din_TREADY), .cpu_din_TLAST(cpu_din_TLAST),
    .cpu_dout_TDATA(cpu_dout_TDATA), .cpu_dout_TVALID(cpu_dout_TVALID),
    .cpu_dout_TREADY(cpu_dout_TREADY), .cpu_dout_TLAST(cpu_dout_TLAST),
    .m0_TDATA(m0_TDATA), .m0_TVALID(m0_TVALID), .m0_TREADY(m0_TREADY), .m0_TLAST(m0_TLAST),
    .m1_TDATA(m1_TDATA), .m1_TVALID(m1_TVALID), .m1_TREADY(m1_TREADY), .m1_TLAST(m1_TLAST),
    .busy(busy), .tag_count(tag_count)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flits are {TLAST, TDATA}.
  logic [32:0] src_q[2][$];   // pending input flits per requester
  logic [32:0] exp_q[2][$];   // flits each requester must get back, in order
  logic [32:0] cpu_q[$];      // echo CPU buffer
  bit          tagq[$];       // reference tag FIFO (requester ids)
  bit          m_busy;
  bit          m_gnt;
`ifdef AXIS_CPU_ARB_RR_EN
  bit          m_last;
`endif

  // Stimulus state (valid is held until its handshake).
  bit          s_vld[2];
  logic [32:0] s_fl[2];
  bit          d_vld;
  logic [32:0] d_fl;

  // Knobs: percent probabilities.
  int p_sv, p_din, p_dout;
  int p_m[2];

  // Statistics taken from DUT pins.
  int n_acc[2];
  int n_out[2];
  int busy_cycles;
  int max_cnt;
  bit seen_m1;
  bit prev_busy;
  int gnt_log[$];

  task automatic clr_stats();
    n_acc = '{0, 0};
    n_out = '{0, 0};
    busy_cycles = 0;
    max_cnt     = 0;
    seen_m1     = 1'b0;
    gnt_log.delete();
  endtask

  task automatic set_knobs(input int sv, input int din, input int dout, input int m0, input int m1);
    p_sv = sv; p_din = din; p_dout = dout; p_m[0] = m0; p_m[1] = m1;
  endtask

  task automatic add_pkt(input int r, input int len);
    logic [32:0] f;
    for (int i = 0; i < len; i++) begin
      f     = {1'b0, 32'($urandom)};
      f[31] = r[0];
      f[32] = (i == len - 1);
      src_q[r].push_back(f);
    end
  endtask

  // --------------------------------------------------------------------------
  // Drive inputs (called just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (!s_vld[r]) begin
        if (src_q[r].size() > 0 && $urandom_range(99) < p_sv) begin
          s_vld[r] = 1'b1;
          s_fl[r]  = src_q[r][0];
        end else begin
          s_fl[r] = {1'b0, 32'($urandom)};
        end
      end
    end
    if (!d_vld) begin
      if (cpu_q.size() > 0 && $urandom_range(99) < p_dout) begin
        d_vld = 1'b1;
        d_fl  = cpu_q[0];
      end else begin
        d_fl = {1'b0, 32'($urandom)};
      end
    end
    s0_TVALID = s_vld[0]; s0_TDATA = s_fl[0][31:0]; s0_TLAST = s_fl[0][32];
    s1_TVALID = s_vld[1]; s1_TDATA = s_fl[1][31:0]; s1_TLAST = s_fl[1][32];
    cpu_dout_TVALID = d_vld; cpu_dout_TDATA = d_fl[31:0]; cpu_dout_TLAST = d_fl[32];
    cpu_din_TREADY = ($urandom_range(99) < p_din);
    m0_TREADY      = ($urandom_range(99) < p_m[0]);
    m1_TREADY      = ($urandom_range(99) < p_m[1]);
  endtask

  // --------------------------------------------------------------------------
  // Check DUT against the reference model and advance it (falling edge)
  // --------------------------------------------------------------------------
  task automatic sample();
    bit          ne, hd, push_ok, both, g, e_din_vld, e_dout_rdy, sf;
    logic [32:0] obs, e;

    ne = (tagq.size() != 0);
    hd = ne ? tagq[0] : 1'b0;

    chk("busy", 64'(busy), 64'(m_busy));
    chk("tag_count", 64'(tag_count), 64'(tagq.size()));
    chk("s0_TREADY", 64'(s0_TREADY), 64'(m_busy && !m_gnt && cpu_din_TREADY));
    chk("s1_TREADY", 64'(s1_TREADY), 64'(m_busy && m_gnt && cpu_din_TREADY));
    e_din_vld = m_busy && s_vld[m_gnt];
    chk("cpu_din_TVALID", 64'(cpu_din_TVALID), 64'(e_din_vld));
    if (e_din_vld)
      chk("cpu_din_flit", 64'({cpu_din_TLAST, cpu_din_TDATA}), 64'(s_fl[m_gnt]));
    e_dout_rdy = ne && (hd ? m1_TREADY : m0_TREADY);
    chk("cpu_dout_TREADY", 64'(cpu_dout_TREADY), 64'(e_dout_rdy));
    chk("m0_TVALID", 64'(m0_TVALID), 64'(d_vld && ne && !hd));
    chk("m1_TVALID", 64'(m1_TVALID), 64'(d_vld && ne && hd));

    // Pin statistics.
    if (s0_TVALID && s0_TREADY) n_acc[0]++;
    if (s1_TVALID && s1_TREADY) n_acc[1]++;
    if (m0_TVALID && m0_TREADY) n_out[0]++;
    if (m1_TVALID && m1_TREADY) n_out[1]++;
    if (busy) busy_cycles++;
    if (int'(tag_count) > max_cnt) max_cnt = int'(tag_count);
    if (m1_TVALID) seen_m1 = 1'b1;
    if (busy && !prev_busy && cpu_din_TVALID) gnt_log.push_back(int'(cpu_din_TDATA[31]));
    prev_busy = busy;

    // Model events; fullness is judged before this cycle's pop.
    push_ok = !m_busy && (s_vld[0] || s_vld[1]) && (tagq.size() < DEPTH);
    both    = s_vld[0] && s_vld[1];

    for (int r = 0; r < 2; r++) begin
      sf = s_vld[r] && m_busy && (m_gnt == r[0]) && cpu_din_TREADY;
      if (sf) begin
        void'(src_q[r].pop_front());
        exp_q[r].push_back(s_fl[r]);
        cpu_q.push_back(s_fl[r]);
        s_vld[r] = 1'b0;
        if (s_fl[r][32]) m_busy = 1'b0;
      end
    end

    if (d_vld && e_dout_rdy) begin
      obs = hd ? {m1_TLAST, m1_TDATA} : {m0_TLAST, m0_TDATA};
      if (exp_q[hd].size() == 0) begin
        chk("m_unexpected_flit", 64'(obs), 64'(0));
      end else begin
        e = exp_q[hd].pop_front();
        chk(hd ? "m1_flit" : "m0_flit", 64'(obs), 64'(e));
      end
      void'(cpu_q.pop_front());
      d_vld = 1'b0;
      if (d_fl[32]) void'(tagq.pop_front());
    end

    if (push_ok) begin
`ifdef AXIS_CPU_ARB_RR_EN
      g      = both ? !m_last : s_vld[1];
      m_last = g;
`else
      g = both ? 1'b0 : s_vld[1];
`endif
      m_busy = 1'b1;
      m_gnt  = g;
      tagq.push_back(g);
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((src_q[0].size() + src_q[1].size() + cpu_q.size() + tagq.size() != 0 || m_busy)
           && c < budget) begin
      step();
      c++;
    end
    chk({tag, "_done"}, 64'(c < budget), 64'(1));
    chk({tag, "_left0"}, 64'(exp_q[0].size()), 64'(0));
    chk({tag, "_left1"}, 64'(exp_q[1].size()), 64'(0));
  endtask

  // Assert reset at the current time, check outputs immediately, release.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'({s0_TREADY, s1_TREADY, cpu_dout_TREADY}), 64'(0));
    chk("rst_valid", 64'({cpu_din_TVALID, m0_TVALID, m1_TVALID}), 64'(0));
    chk("rst_data", 64'(cpu_din_TDATA | m0_TDATA | m1_TDATA), 64'(0));
    chk("rst_last", 64'({cpu_din_TLAST, m0_TLAST, m1_TLAST}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_tag_count", 64'(tag_count), 64'(0));
    for (int r = 0; r < 2; r++) begin
      src_q[r].delete();
      exp_q[r].delete();
      s_vld[r] = 1'b0;
    end
    cpu_q.delete();
    tagq.delete();
    d_vld  = 1'b0;
    m_busy = 1'b0;
    m_gnt  = 1'b0;
`ifdef AXIS_CPU_ARB_RR_EN
    m_last = 1'b1;
`endif
    prev_busy = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive();
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    set_knobs(100, 100, 100, 100, 100);
    s_vld = '{1'b0, 1'b0};
    d_vld = 1'b0;
    clr_stats();
    #2;
    do_reset();

    // Single packet through s0.
    clr_stats();
    src_q[0].push_back({1'b0, 32'h11});
    src_q[0].push_back({1'b0, 32'h22});
    src_q[0].push_back({1'b1, 32'h33});
    drain("t1", 50);
    chk("t1_busy_cycles", 64'(busy_cycles), 64'(3));
    chk("t1_max_tag_count", 64'(max_cnt), 64'(1));
    chk("t1_m0_flits", 64'(n_out[0]), 64'(3));
    chk("t1_m1_valid_seen", 64'(seen_m1), 64'(0));

    // Contention right after reset: s0 has two packets, s1 one.
    do_reset();
    clr_stats();
    add_pkt(0, 2);
    add_pkt(1, 2);
    add_pkt(0, 2);
    drain("t2", 100);
    chk("t2_grants", 64'(gnt_log.size()), 64'(3));
    if (gnt_log.size() == 3) begin
      chk("t2_grant0", 64'(gnt_log[0]), 64'(0));
`ifdef AXIS_CPU_ARB_RR_EN
      chk("t2_grant1", 64'(gnt_log[1]), 64'(1));
      chk("t2_grant2", 64'(gnt_log[2]), 64'(0));
`else
      chk("t2_grant1", 64'(gnt_log[1]), 64'(0));
      chk("t2_grant2", 64'(gnt_log[2]), 64'(1));
`endif
    end

    // FIFO full: results to m0 blocked, five one-flit packets.
    clr_stats();
    set_knobs(100, 100, 100, 0, 100);
    for (int i = 0; i < 5; i++) add_pkt(0, 1);
    run(20);
    chk("t3_tag_count_full", 64'(tag_count), 64'(DEPTH));
    chk("t3_accepted", 64'(n_acc[0]), 64'(4));
    chk("t3_s0_TREADY", 64'(s0_TREADY), 64'(0));
    p_m[0] = 100;
    drain("t3", 100);
    chk("t3_accepted_all", 64'(n_acc[0]), 64'(5));
    chk("t3_m0_flits", 64'(n_out[0]), 64'(5));

    // Egress back-pressure on m1.
    clr_stats();
    set_knobs(100, 100, 100, 100, 0);
    add_pkt(1, 2);
    run(15);
    chk("t4_m1_flits_held", 64'(n_out[1]), 64'(0));
    chk("t4_tag_count", 64'(tag_count), 64'(1));
    chk("t4_cpu_dout_TREADY", 64'(cpu_dout_TREADY), 64'(0));
    p_m[1] = 100;
    drain("t4", 50);
    chk("t4_m1_flits", 64'(n_out[1]), 64'(2));

    // Reset after flit 2 of a 4-flit packet, then a normal packet.
    clr_stats();
    set_knobs(100, 100, 100, 100, 100);
    add_pkt(0, 4);
    for (int c = 0; c < 20 && n_acc[0] < 2; c++) step();
    chk("t5_two_flits", 64'(n_acc[0]), 64'(2));
    do_reset();
    clr_stats();
    add_pkt(0, 2);
    drain("t5", 50);
    chk("t5_m0_flits", 64'(n_out[0]), 64'(2));

    // Randomized traffic.
    for (int round = 0; round < 3; round++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 20),
                $urandom_range(100, 20), $urandom_range(100, 20));
      for (int k = 0; k < 15; k++) begin
        add_pkt(0, $urandom_range(4, 1));
        add_pkt(1, $urandom_range(4, 1));
      end
      drain("rand", 5000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axis_cpu_pkt_arb.md
# axis_cpu_pkt_arb

Packet-level arbiter that shares one `axis_cpu` datapath between two AXI-Stream requesters. It grants whole input packets (TLAST-delimited) to the CPU's `din` port and records the winning requester in a tag FIFO. It then steers each CPU `dout` packet back to the requester at the FIFO head. It sits directly in front of and behind `axis_cpu`; the CPU itself is untouched.

## Interface
Parameters:
- `DATA_WIDTH`, 32: TDATA width on all streams.
- `TAG_DEPTH_LOG2`, 2: log2 of tag FIFO depth; default depth 4 outstanding packets.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `s0_TDATA/TVALID/TREADY/TLAST`  in/in/out/in  DATA_WIDTH/1/1/1  requester 0 input packets.
- `s1_TDATA/TVALID/TREADY/TLAST`  in/in/out/in  DATA_WIDTH/1/1/1  requester 1 input packets.
- `cpu_din_TDATA/TVALID/TREADY/TLAST`  out/out/in/out  DATA_WIDTH/1/1/1  to `axis_cpu` `din`.
- `cpu_dout_TDATA/TVALID/TREADY/TLAST`  in/in/out/in  DATA_WIDTH/1/1/1  from `axis_cpu` `dout`.
- `m0_TDATA/TVALID/TREADY/TLAST`  out/out/in/out  DATA_WIDTH/1/1/1  results back to requester 0.
- `m1_TDATA/TVALID/TREADY/TLAST`  out/out/in/out  DATA_WIDTH/1/1/1  results back to requester 1.
- `busy`  out  1  high while a grant is locked (state BUSY).
- `tag_count`  out  TAG_DEPTH_LOG2+1  packets granted but whose result is not yet fully returned.

## Operation
- Flit = TVALID && TREADY on the same edge.
- Ingress FSM, two states:
  - IDLE: all `sN_TREADY`=0, `cpu_din_TVALID`=0.
    - If any `sN_TVALID`=1 and tag FIFO not full: register grant `g`, push `g` into tag FIFO, go to BUSY.
    - Otherwise stay in IDLE. A full FIFO blocks the grant; valid requesters wait.
  - BUSY: `cpu_din_*` = `s[g]_*` passthrough; `s[g]_TREADY` = `cpu_din_TREADY`; other requester's TREADY=0.
    - A flit with TLAST=1 returns the FSM to IDLE.
- Grant selection: see Configuration. `last_grant` register is updated at each grant.
- Egress, combinational steering from the FIFO head `h`:
  - `m[h]_TVALID` = `cpu_dout_TVALID` && FIFO non-empty; the other `m` has TVALID=0.
  - `cpu_dout_TREADY` = FIFO non-empty && `m[h]_TREADY`.
  - `mN_TDATA`/`TLAST` mirror `cpu_dout`.
- A `cpu_dout` flit with TLAST=1 pops the FIFO.
- With the FIFO empty, `cpu_dout_TREADY`=0; a stray CPU output is stalled, not dropped.
- Simultaneous push and pop in one cycle: `tag_count` is unchanged and the head advances correctly. A push while a pop frees the last slot is not allowed; fullness is judged on the registered count.
- Pointer and count arithmetic is modulo 2^TAG_DEPTH_LOG2; `tag_count` is a separate counter in the range 0..2^TAG_DEPTH_LOG2.
- Reset, asserted at any time including mid-packet: FSM→IDLE, FIFO pointers and count →0, `last_grant`=1. Any partial packets are abandoned; the requester is responsible for resending them.

## Timing
- Reset values: all TREADY=0, all output TVALID=0, TLAST=0, TDATA=0 (gated), `busy`=0, `tag_count`=0.
- Arbitration latency: 1 cycle. A TVALID first seen in IDLE produces its first possible flit on the next cycle.
- Between back-to-back packets there is exactly one bubble cycle (the IDLE cycle after TLAST).
- Data path: zero-latency combinational passthrough in both directions; no registering of TDATA.
- Back-pressure propagates combinationally: `cpu_din_TREADY`→`s[g]_TREADY`, `m[h]_TREADY`→`cpu_dout_TREADY`.
- `tag_count` updates on the edge of the push or pop.

## Configuration
- `AXIS_CPU_ARB_RR_EN` defined: round-robin. When both requesters are valid in IDLE, grant goes to `~last_grant`; when only one is valid, it is granted.
- Undefined: fixed priority. Requester 0 always wins when both are valid, and `last_grant` is unused. Starvation of requester 1 is permitted in this mode.

## Test plan
- Single packet: s0 sends 3 flits (0x11, 0x22, 0x33+TLAST); CPU echoes them. Required: `busy` high for 3 cycles; `tag_count` 0→1→0; m0 receives 0x11/0x22/0x33 with TLAST on the last flit; m1_TVALID stays 0.
- Contention: s0 and s1 both valid with 2-flit packets in the same cycle. RR build: s0 granted first (`last_grant`=1 after reset), then s1 after one bubble; outputs return to m0 then m1. Fixed build: s0 first, and s0 wins again if it re-requests.
- FIFO full: CPU `dout` held with TREADY to it effectively 0 (`m0_TREADY`=0); s0 sends 5 one-flit packets. Required: 4 grants, `tag_count`=4, 5th packet sees TREADY=0 until one result pops, then it is granted.
- Egress back-pressure: `m1_TREADY`=0 while the head is 1. Required: `cpu_dout_TREADY`=0 and no pop; release → flits delivered in order.
- Reset mid-packet: assert `rst`=0 after flit 2 of 4. Required: same cycle, all TREADY/TVALID=0, `busy`=0, `tag_count`=0; after release the FSM is in IDLE and the next packet is granted normally.
